// File: rtl/bcd_conv_sched.sv
`default_nettype none
// ============================================================================
// Module      : bcd_conv_sched
// Description : Round-robin scheduler that shares one hex2bcd converter among
//               NCH channels. Per-channel requests are latched as pending
//               bits. One channel at a time gets a start pulse with its
//               (clamped to 99) value, and the returned BCD digits are
//               stored in that channel's output register.
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous reset, active-low
//               req        - per-channel request, sampled every clock
//               din        - packed channel values, ch i at [i*DW +: DW]
//               conv_start - one-cycle start pulse to the converter
//               conv_din   - converter operand, stable from start to done
//               conv_done  - converter completion
//               conv_bcd_h - converter tens digit
//               conv_bcd_l - converter units digit
//               bcd_out    - packed results, ch i = {tens,units} at [i*8 +: 8]
//               ack        - one-cycle pulse when ch i result is written
//               busy       - high whenever the FSM is not idle
//               err        - sticky per-channel timeout flags
// Options     : BCD_SCHED_TIMEOUT_EN - when defined, abandon a conversion
//               after TIMEOUT_CYC cycles in WAIT and flag err for the
//               channel. Otherwise WAIT is unbounded and err is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_conv_sched #(
   parameter int NCH         = 3,
   parameter int DW          = 7,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NCH-1:0]      req,
   input  logic [NCH*DW-1:0]   din,
   output logic                conv_start,
   output logic [DW-1:0]       conv_din,
   input  logic                conv_done,
   input  logic [3:0]          conv_bcd_h,
   input  logic [3:0]          conv_bcd_l,
   output logic [NCH*8-1:0]    bcd_out,
   output logic [NCH-1:0]      ack,
   output logic                busy,
   output logic [NCH-1:0]      err
);

   localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_STORE = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [NCH-1:0]      r_pending;
   logic [NCH-1:0]      w_pend_clr;
   logic [PW-1:0]       r_rr_ptr;
   logic [PW-1:0]       r_gch;
   logic [PW-1:0]       w_grant;
   logic                w_grant_vld;
   logic [PW-1:0]       w_gch_next;
   logic [DW-1:0]       w_din_ch [NCH];
   logic [DW-1:0]       w_din_raw;
   logic [DW-1:0]       w_din_clamp;
   logic [DW-1:0]       r_conv_din;
   logic [NCH*8-1:0]    r_bcd_out;
   logic                w_timeout;

   // ------------------------------------------------------------------------
   // Unpack channel values
   // ------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
         assign w_din_ch[gi] = din[gi*DW +: DW];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Round-robin grant: first pending channel at or after rr_ptr, wrapping.
   // The loop walks offsets from high to low so the smallest offset is the
   // last assignment and therefore wins.
   // ------------------------------------------------------------------------
   always_comb begin
      int idx;
      w_grant     = r_rr_ptr;
      w_grant_vld = 1'b0;
      idx         = 0;
      for (int k = NCH - 1; k >= 0; k--) begin
         idx = int'(r_rr_ptr) + k;
         if (idx >= NCH) begin
            idx = idx - NCH;
         end
         if (r_pending[idx[PW-1:0]]) begin
            w_grant     = idx[PW-1:0];
            w_grant_vld = 1'b1;
         end
      end
   end

   // The converter only produces two digits, so larger values saturate.
   assign w_din_raw   = w_din_ch[w_grant];
   assign w_din_clamp = (w_din_raw > DW'(99)) ? DW'(99) : w_din_raw;

   // Pointer to the channel after the current grant, wrapping.
   assign w_gch_next  = (r_gch == PW'(NCH - 1)) ? '0 : r_gch + PW'(1);

   // ------------------------------------------------------------------------
   // Pending request bits: a request in the clearing cycle keeps the bit set.
   // ------------------------------------------------------------------------
   always_comb begin
      w_pend_clr = '0;
      if (r_state == S_ISSUE) begin
         w_pend_clr[r_gch] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_pend_clr) | req;
      end
   end

   // ------------------------------------------------------------------------
   // Optional WAIT timeout
   // ------------------------------------------------------------------------
`ifdef BCD_SCHED_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   logic [CW-1:0]  r_wcnt;
   logic [NCH-1:0] r_err;

   // Held at zero outside WAIT, so every WAIT entry starts counting from 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wcnt <= '0;
      end else if (r_state != S_WAIT) begin
         r_wcnt <= '0;
      end else begin
         r_wcnt <= r_wcnt + CW'(1);
      end
   end

   // A done arriving on the last allowed cycle still completes normally.
   assign w_timeout = (r_state == S_WAIT) && !conv_done &&
                      (r_wcnt == CW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err <= '0;
      end else if (w_timeout) begin
         r_err[r_gch] <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign w_timeout = 1'b0;
   assign err       = '0;
`endif

   // ------------------------------------------------------------------------
   // FSM state register and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_rr_ptr   <= '0;
         r_gch      <= '0;
         r_conv_din <= '0;
         r_bcd_out  <= '0;
      end else begin
         r_state <= w_state_nxt;

         // The operand is captured while entering ISSUE so it is already
         // valid alongside the start pulse and holds until the next grant.
         if (r_state == S_IDLE && w_grant_vld) begin
            r_gch      <= w_grant;
            r_conv_din <= w_din_clamp;
         end

         // Result is written on the done edge so bcd_out and ack appear in
         // the same (STORE) cycle.
         if (r_state == S_WAIT && conv_done) begin
            r_bcd_out[r_gch*8 +: 8] <= {conv_bcd_h, conv_bcd_l};
         end

         if (r_state == S_STORE || w_timeout) begin
            r_rr_ptr <= w_gch_next;
         end
      end
   end

   // ------------------------------------------------------------------------
   // FSM next state and outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      conv_start  = 1'b0;
      ack         = '0;
      busy        = 1'b1;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (w_grant_vld) begin
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            conv_start  = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (conv_done) begin
               w_state_nxt = S_STORE;
            end else if (w_timeout) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_STORE: begin
            ack[r_gch]  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign conv_din = r_conv_din;
   assign bcd_out  = r_bcd_out;

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bcd_conv_sched
// Description : Self-checking bench for bcd_conv_sched with a behavioural
//               hex2bcd responder and a scoreboard of expected operands and
//               results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_conv_sched;

   localparam int NCH = 3;
   localparam int DW  = 7;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    req;
   logic [NCH*DW-1:0] din;
   logic              conv_start;
   logic [DW-1:0]     conv_din;
   logic              conv_done;
   logic [3:0]        conv_bcd_h;
   logic [3:0]        conv_bcd_l;
   logic [NCH*8-1:0]  bcd_out;
   logic [NCH-1:0]    ack;
   logic              busy;
   logic [NCH-1:0]    err;

   bcd_conv_sched #(.NCH(NCH), .DW(DW), .TIMEOUT_CYC(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .din        (din),
      .conv_start (conv_start),
      .conv_din   (conv_din),
      .conv_done  (conv_done),
      .conv_bcd_h (conv_bcd_h),
      .conv_bcd_l (conv_bcd_l),
      .bcd_out    (bcd_out),
      .ack        (ack),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int         ch;
      logic [7:0] bcd;
   } res_t;

   logic [DW-1:0] q_issue [$];
   res_t          q_res   [$];
   logic [7:0]    model_out [NCH];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [23:0] pack_model();
      logic [23:0] v;
      v = '0;
      for (int i = 0; i < NCH; i++) v[i*8 +: 8] = model_out[i];
      return v;
   endfunction

   // ------------------------------------------------------------------------
   // Behavioural converter: done conv_lat cycles after the start cycle.
   // ------------------------------------------------------------------------
   int            conv_lat  = 1;
   bit            hold_done = 1'b0;
   bit            rsp_active = 1'b0;
   int            rsp_cnt    = 0;
   logic [DW-1:0] rsp_din;

   initial begin
      conv_done  = 1'b0;
      conv_bcd_h = 4'd0;
      conv_bcd_l = 4'd0;
      forever begin
         @(negedge clk);
         conv_done = 1'b0;
         if (!rst) begin
            rsp_active = 1'b0;
         end else begin
            if (rsp_active) begin
               if (rsp_cnt == 0) begin
                  chk("conv_din_hold", 32'(conv_din), 32'(rsp_din));
                  conv_bcd_h = 4'(rsp_din / 10);
                  conv_bcd_l = 4'(rsp_din % 10);
                  conv_done  = 1'b1;
                  rsp_active = 1'b0;
               end else begin
                  rsp_cnt--;
               end
            end
            if (conv_start && !hold_done) begin
               rsp_active = 1'b1;
               rsp_cnt    = conv_lat - 1;
               rsp_din    = conv_din;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Scoreboard monitors
   // ------------------------------------------------------------------------
   logic          prev_start = 1'b0;
   logic [DW-1:0] mon_exp;
   res_t          mon_res;

   always @(negedge clk) begin
      if (rst && conv_start) begin
         chk("start_width", {30'd0, prev_start, conv_start}, 32'd1);
         if (q_issue.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_start: conv_din=%0d, expected no start", conv_din);
         end else begin
            mon_exp = q_issue.pop_front();
            chk("conv_din", 32'(conv_din), 32'(mon_exp));
         end
      end
      prev_start = rst && conv_start;

      if (rst && ack != '0) begin
         if (q_res.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_ack: ack=%b, expected none", ack);
         end else begin
            mon_res = q_res.pop_front();
            model_out[mon_res.ch] = mon_res.bcd;
            chk("ack", 32'(ack), 32'(1 << mon_res.ch));
            chk("bcd_out", 32'(bcd_out), 32'(pack_model()));
         end
      end
   end

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   task automatic pulse_req(input logic [NCH-1:0] m);
      @(negedge clk);
      req = m;
      @(negedge clk);
      req = '0;
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int c;
      c = 0;
      do begin
         @(negedge clk);
         c++;
      end while ((busy || q_issue.size() != 0 || q_res.size() != 0) && c < budget);
      if (c >= budget) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: still busy=%0b after %0d cycles, expected idle", nm, busy, c);
         q_issue.delete();
         q_res.delete();
      end
   endtask

   typedef struct {
      int         ch;
      int         val;
      int         lat;
      logic [6:0] exp_din;
      logic [7:0] exp_bcd;
   } vec_t;

   vec_t vecs [7];

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   initial begin
      int c;
      int t_start;
      int t_ack;
      int busy_seen;

      vecs[0] = '{1, 120, 2, 7'd99, 8'h99};
      vecs[1] = '{2,   0, 3, 7'd0,  8'h00};
      vecs[2] = '{0,  99, 1, 7'd99, 8'h99};
      vecs[3] = '{1, 100, 1, 7'd99, 8'h99};
      vecs[4] = '{0, 127, 2, 7'd99, 8'h99};
      vecs[5] = '{1,  10, 1, 7'd10, 8'h10};
      vecs[6] = '{2,  59, 5, 7'd59, 8'h59};

      for (int i = 0; i < NCH; i++) model_out[i] = 8'h00;
      rst = 1'b0;
      req = '0;
      din = '0;
      repeat (3) @(negedge clk);
      chk("rst_bcd_out", 32'(bcd_out), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_conv_start", 32'(conv_start), 32'd0);
      chk("rst_conv_din", 32'(conv_din), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Single request with latency measurement: start at cycle 2, ack at 3+k.
      din[0*DW +: DW] = 7'd45;
      conv_lat = 1;
      q_issue.push_back(7'd45);
      q_res.push_back('{0, 8'h45});
      @(negedge clk);
      req = 3'b001;
      c = 0; t_start = -1; t_ack = -1;
      while (c < 50 && t_ack < 0) begin
         @(negedge clk);
         req = '0;
         c++;
         if (conv_start && t_start < 0) t_start = c;
         if (ack != '0) t_ack = c;
      end
      chk("lat_start", 32'(t_start), 32'd2);
      chk("lat_ack", 32'(t_ack), 32'd4);
      wait_idle("single", 50);

      // Table of single-channel conversions, including clamp boundaries.
      for (int i = 0; i < 7; i++) begin
         din[vecs[i].ch*DW +: DW] = DW'(vecs[i].val);
         conv_lat = vecs[i].lat;
         q_issue.push_back(vecs[i].exp_din);
         q_res.push_back('{vecs[i].ch, vecs[i].exp_bcd});
         pulse_req(NCH'(1 << vecs[i].ch));
         wait_idle("vec", 100);
         chk("vec_bcd_slice", 32'(bcd_out[vecs[i].ch*8 +: 8]), 32'(vecs[i].exp_bcd));
      end

      // Round-robin: all three at once, last served was ch2 so order is 0,1,2.
      din = {7'd12, 7'd23, 7'd59};
      conv_lat = 1;
      q_issue.push_back(7'd59); q_issue.push_back(7'd23); q_issue.push_back(7'd12);
      q_res.push_back('{0, 8'h59}); q_res.push_back('{1, 8'h23}); q_res.push_back('{2, 8'h12});
      pulse_req(3'b111);
      wait_idle("rr", 100);
      chk("rr_bcd_out", 32'(bcd_out), 32'h122359);

      // Re-request during ISSUE, with din changing mid-WAIT.
      din[0*DW +: DW] = 7'd33;
      conv_lat = 4;
      q_issue.push_back(7'd33); q_res.push_back('{0, 8'h33});
      q_issue.push_back(7'd77); q_res.push_back('{0, 8'h77});
      pulse_req(3'b001);
      c = 0;
      while (!conv_start && c < 20) begin
         @(negedge clk);
         c++;
      end
      req = 3'b001;
      @(negedge clk);
      req = '0;
      din[0*DW +: DW] = 7'd77;
      wait_idle("rereq", 100);
      chk("rereq_ch0", 32'(bcd_out[7:0]), 32'h77);

      // Reset in the middle of WAIT with another request pending.
      hold_done = 1'b1;
      din[1*DW +: DW] = 7'd50;
      q_issue.push_back(7'd50);
      pulse_req(3'b010);
      c = 0;
      while (!conv_start && c < 20) begin
         @(negedge clk);
         c++;
      end
      @(negedge clk);
      req = 3'b100;
      @(negedge clk);
      req = '0;
      rst = 1'b0;
      #1;
      chk("mid_rst_bcd_out", 32'(bcd_out), 32'd0);
      chk("mid_rst_ack", 32'(ack), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_conv_start", 32'(conv_start), 32'd0);
      chk("mid_rst_conv_din", 32'(conv_din), 32'd0);
      chk("mid_rst_err", 32'(err), 32'd0);
      q_issue.delete();
      q_res.delete();
      for (int i = 0; i < NCH; i++) model_out[i] = 8'h00;
      @(negedge clk);
      rst = 1'b1;
      hold_done = 1'b0;
      busy_seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (busy) busy_seen++;
      end
      chk("pending_cleared", 32'(busy_seen), 32'd0);

`ifdef BCD_SCHED_TIMEOUT_EN
      // Timeout on ch0, then ch1 (also pending) is served normally.
      hold_done = 1'b1;
      conv_lat = 1;
      din[0*DW +: DW] = 7'd5;
      din[1*DW +: DW] = 7'd6;
      q_issue.push_back(7'd5); q_issue.push_back(7'd6);
      q_res.push_back('{1, 8'h06});
      pulse_req(3'b011);
      c = 0;
      while (!conv_start && c < 20) begin
         @(negedge clk);
         c++;
      end
      c = 0;
      do begin
         @(negedge clk);
         hold_done = 1'b0;
         c++;
      end while (err == '0 && c < 200);
      chk("timeout_delay", 32'(c), 32'd65);
      chk("timeout_err", 32'(err), 32'b001);
      wait_idle("after_timeout", 100);
      chk("after_timeout_ch1", 32'(bcd_out[15:8]), 32'h06);
      chk("err_final", 32'(err), 32'b001);
`else
      chk("err_final", 32'(err), 32'd0);
`endif

      repeat (3) @(negedge clk);
      chk("final_busy", 32'(busy), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
